// File: rtl/xcvr_ber_test_sequencer.sv
// xcvr_ber_test_sequencer
// Autonomous bit-error-rate test sequencer. Acts as a simple Avalon-MM master
// on the CSR slave of one data pattern checker. For each run it selects the
// pattern, clears and enables the checker, waits for pattern lock, dwells,
// snapshots the 64-bit bit and error counters, and reports pass/fail.
//
// Optional build macro: BER_SEQ_CONTINUOUS_EN
//   When defined, the sequencer loops SNAP -> DWELL without clearing the
//   checker. It pulses done at every snapshot and evaluates pass on the
//   cumulative error count. Only stop leads to the disable write.
//   When undefined, each start produces exactly one measurement.

module xcvr_ber_test_sequencer #(
  parameter int LOCK_TIMEOUT = 65535,
  parameter int DWELL_W      = 32
) (
  input  logic               csr_clk_clk,
  input  logic               reset_reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic [2:0]         pattern_sel,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [2:0]         m_address,
  output logic               m_write,
  output logic               m_read,
  output logic [3:0]         m_byteenable,
  output logic [31:0]        m_writedata,
  input  logic [31:0]        m_readdata,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               lock_fail,
  output logic [63:0]        bit_count,
  output logic [63:0]        err_count
);

  // Checker CSR addresses
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_PATTERN = 3'd2;
  localparam logic [2:0] ADDR_BIT_LO  = 3'd3;
  localparam logic [2:0] ADDR_BIT_HI  = 3'd4;
  localparam logic [2:0] ADDR_ERR_LO  = 3'd5;
  localparam logic [2:0] ADDR_ERR_HI  = 3'd6;

  // Sequencer states. PAT..SNAP_W are contiguous so that the "stop may
  // abort here" window is a simple range compare.
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_PAT      = 4'd1;
  localparam logic [3:0] ST_CLR      = 4'd2;
  localparam logic [3:0] ST_EN       = 4'd3;
  localparam logic [3:0] ST_POLL     = 4'd4;
  localparam logic [3:0] ST_POLL_W   = 4'd5;
  localparam logic [3:0] ST_DWELL    = 4'd6;
  localparam logic [3:0] ST_SNAP0    = 4'd7;
  localparam logic [3:0] ST_SNAP1    = 4'd8;
  localparam logic [3:0] ST_SNAP2    = 4'd9;
  localparam logic [3:0] ST_SNAP3    = 4'd10;
  localparam logic [3:0] ST_SNAP_W   = 4'd11;
  localparam logic [3:0] ST_SNAP_UPD = 4'd12;
  localparam logic [3:0] ST_CREP     = 4'd13;
  localparam logic [3:0] ST_DIS      = 4'd14;
  localparam logic [3:0] ST_DONE     = 4'd15;

  // Poll counter only has to reach LOCK_TIMEOUT-1
  localparam int POLL_CW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT);
  localparam logic [POLL_CW-1:0] POLL_LAST = POLL_CW'(LOCK_TIMEOUT - 1);

  logic [3:0]         state;
  logic [3:0]         next_state;
  logic [2:0]         pat_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [POLL_CW-1:0] poll_cnt;
  logic [31:0]        sh_bit_lo;
  logic [31:0]        sh_bit_hi;
  logic [31:0]        sh_err_lo;
  logic [31:0]        sh_err_hi;
  logic               measured;
  logic               in_run;
  logic               abort;
  logic               locked;
  logic               last_poll;
  logic               dwell_done;

  assign in_run     = (state >= ST_PAT) && (state <= ST_SNAP_W);
  assign abort      = stop && in_run;
  assign locked     = m_readdata[0];
  assign last_poll  = (poll_cnt == POLL_LAST);
  assign dwell_done = (dwell_cnt == (dwell_q - DWELL_W'(1)));

  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE) || (state == ST_CREP);
  assign m_byteenable = (m_write || m_read) ? 4'hF : 4'h0;

  // Next-state decode; an abort during a run always heads for the disable write
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = ST_DIS;
    end else begin
      case (state)
        ST_IDLE:     if (start) next_state = ST_PAT;
        ST_PAT:      next_state = ST_CLR;
        ST_CLR:      next_state = ST_EN;
        ST_EN:       next_state = ST_POLL;
        ST_POLL:     next_state = ST_POLL_W;
        ST_POLL_W: begin
          if (locked)         next_state = ST_DWELL;
          else if (last_poll) next_state = ST_DIS;
          else                next_state = ST_POLL;
        end
        ST_DWELL:    if (dwell_done) next_state = ST_SNAP0;
        ST_SNAP0:    next_state = ST_SNAP1;
        ST_SNAP1:    next_state = ST_SNAP2;
        ST_SNAP2:    next_state = ST_SNAP3;
        ST_SNAP3:    next_state = ST_SNAP_W;
        ST_SNAP_W:   next_state = ST_SNAP_UPD;
`ifdef BER_SEQ_CONTINUOUS_EN
        ST_SNAP_UPD: next_state = stop ? ST_DIS : ST_CREP;
        ST_CREP:     next_state = ST_DWELL;
`else
        ST_SNAP_UPD: next_state = ST_DIS;
        ST_CREP:     next_state = ST_IDLE;
`endif
        ST_DIS:      next_state = ST_DONE;
        ST_DONE:     next_state = ST_IDLE;
        default:     next_state = ST_IDLE;
      endcase
    end
  end

  // CSR master strobes decoded from the state; one access per state
  always_comb begin
    m_address   = 3'd0;
    m_write     = 1'b0;
    m_read      = 1'b0;
    m_writedata = 32'h0;
    case (state)
      ST_PAT: begin
        m_write     = 1'b1;
        m_address   = ADDR_PATTERN;
        m_writedata = {29'b0, pat_q};
      end
      ST_CLR: begin
        m_write     = 1'b1;
        m_address   = ADDR_CTRL;
        m_writedata = 32'h2;
      end
      ST_EN: begin
        m_write     = 1'b1;
        m_address   = ADDR_CTRL;
        m_writedata = 32'h1;
      end
      ST_POLL: begin
        m_read    = 1'b1;
        m_address = ADDR_STATUS;
      end
      ST_SNAP0: begin
        m_read    = 1'b1;
        m_address = ADDR_BIT_LO;
      end
      ST_SNAP1: begin
        m_read    = 1'b1;
        m_address = ADDR_BIT_HI;
      end
      ST_SNAP2: begin
        m_read    = 1'b1;
        m_address = ADDR_ERR_LO;
      end
      ST_SNAP3: begin
        m_read    = 1'b1;
        m_address = ADDR_ERR_HI;
      end
      ST_DIS: begin
        m_write     = 1'b1;
        m_address   = ADDR_CTRL;
        m_writedata = 32'h0;
      end
      default: begin
        m_write = 1'b0;
      end
    endcase
  end

  // State register, run bookkeeping, snapshot capture and result flags
  always_ff @(posedge csr_clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= ST_IDLE;
      pat_q     <= 3'd0;
      dwell_q   <= DWELL_W'(1);
      dwell_cnt <= '0;
      poll_cnt  <= '0;
      sh_bit_lo <= 32'h0;
      sh_bit_hi <= 32'h0;
      sh_err_lo <= 32'h0;
      sh_err_hi <= 32'h0;
      bit_count <= 64'h0;
      err_count <= 64'h0;
      pass      <= 1'b0;
      lock_fail <= 1'b0;
      measured  <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pass      <= 1'b0;
            lock_fail <= 1'b0;
            measured  <= 1'b0;
            poll_cnt  <= '0;
            dwell_cnt <= '0;
            pat_q     <= pattern_sel;
            dwell_q   <= (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
          end
        end
        ST_POLL_W: begin
          if (!abort && !locked) begin
            if (last_poll) lock_fail <= 1'b1;
            else           poll_cnt  <= poll_cnt + POLL_CW'(1);
          end
        end
        ST_DWELL: begin
          if (dwell_done) dwell_cnt <= '0;
          else            dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
        ST_SNAP1:  sh_bit_lo <= m_readdata;
        ST_SNAP2:  sh_bit_hi <= m_readdata;
        ST_SNAP3:  sh_err_lo <= m_readdata;
        ST_SNAP_W: sh_err_hi <= m_readdata;
        ST_SNAP_UPD: begin
          bit_count <= {sh_bit_hi, sh_bit_lo};
          err_count <= {sh_err_hi, sh_err_lo};
`ifdef BER_SEQ_CONTINUOUS_EN
          if (stop) begin
            measured <= 1'b0;
          end else begin
            measured <= 1'b1;
            pass     <= ({sh_err_hi, sh_err_lo} == 64'h0);
          end
`else
          measured <= 1'b1;
`endif
        end
        ST_DIS: begin
          pass <= measured && !lock_fail && (err_count == 64'h0);
        end
        default: begin
          pass <= pass;
        end
      endcase
      if (abort) measured <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xcvr_ber_test_sequencer.sv
// Testbench for xcvr_ber_test_sequencer: a behavioural checker CSR slave
// answers the sequencer, and every run is compared against an access list
// and result set derived from the sequencing rules with plain arithmetic.

module tb_xcvr_ber_test_sequencer;

  localparam int LT = 8;

  logic        csr_clk_clk   = 1'b0;
  logic        reset_reset_n = 1'b1;
  logic        start         = 1'b0;
  logic        stop          = 1'b0;
  logic [2:0]  pattern_sel   = 3'd0;
  logic [31:0] dwell_cycles  = 32'd0;
  logic [2:0]  m_address;
  logic        m_write;
  logic        m_read;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        lock_fail;
  logic [63:0] bit_count;
  logic [63:0] err_count;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;

  // Checker model state
  logic [63:0] chkBits  = 64'h0;
  logic [63:0] chkErrs  = 64'h0;
  int          lockPolls = 0;
  int          statusReads = 0;
  int          pollBase = 0;
  logic [72:0] accLog[$];

  // Expected last snapshot held by the sequencer
  logic [63:0] snapBits = 64'h0;
  logic [63:0] snapErrs = 64'h0;

  xcvr_ber_test_sequencer #(.LOCK_TIMEOUT(LT), .DWELL_W(32)) dut (
    .csr_clk_clk  (csr_clk_clk),
    .reset_reset_n(reset_reset_n),
    .start        (start),
    .stop         (stop),
    .pattern_sel  (pattern_sel),
    .dwell_cycles (dwell_cycles),
    .m_address    (m_address),
    .m_write      (m_write),
    .m_read       (m_read),
    .m_byteenable (m_byteenable),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .lock_fail    (lock_fail),
    .bit_count    (bit_count),
    .err_count    (err_count)
  );

  always #5 csr_clk_clk = ~csr_clk_clk;

  // Checker CSR slave: logs every access with its cycle number and returns
  // read data exactly one cycle later (random junk otherwise)
  always @(posedge csr_clk_clk) begin
    if (m_read || m_write)
      accLog.push_back({cyc, m_read, m_write, m_byteenable, m_address,
                        (m_write ? m_writedata : 32'h0)});
    if (m_read) begin
      case (m_address)
        3'd1: begin
          m_readdata  <= {31'b0, ((statusReads - pollBase) >= lockPolls)};
          statusReads <= statusReads + 1;
        end
        3'd3:    m_readdata <= chkBits[31:0];
        3'd4:    m_readdata <= chkBits[63:32];
        3'd5:    m_readdata <= chkErrs[31:0];
        3'd6:    m_readdata <= chkErrs[63:32];
        default: m_readdata <= 32'h0;
      endcase
    end else begin
      m_readdata <= $urandom;
    end
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [72:0] mkAcc(input int c, input bit rd, input bit wr,
                                        input logic [2:0] a, input logic [31:0] d);
    return {32'(c), rd, wr, 4'hF, a, d};
  endfunction

  // One complete run: drive start, optionally stop/re-pulse start, then check
  // result outputs and the full CSR access list against the rule-based model
  task automatic applyStimulus(input logic [2:0] pat, input int dwell, input int lockp,
                               input logic [63:0] bits, input logic [63:0] errs,
                               input int stopOff, input bit repulse);
    logic [72:0] expq[$];
    int  t0, ne, npolls, d, dis, doneExp, doneCyc, logBase, n;
    bit  locked, aborted, seen, passExp;
    pattern_sel  = pat;
    dwell_cycles = 32'(dwell);
    lockPolls    = lockp;
    chkBits      = bits;
    chkErrs      = errs;
    pollBase     = statusReads;
    logBase      = accLog.size();

    @(negedge csr_clk_clk);
    t0    = int'(cyc);
    start = 1'b1;

    ne      = (dwell == 0) ? 1 : dwell;
    locked  = (lockp < LT);
    aborted = (stopOff >= 0);
    expq.push_back(mkAcc(t0 + 1, 0, 1, 3'd2, {29'b0, pat}));
    expq.push_back(mkAcc(t0 + 2, 0, 1, 3'd0, 32'h2));
    expq.push_back(mkAcc(t0 + 3, 0, 1, 3'd0, 32'h1));
    npolls = locked ? lockp + 1 : LT;
    if (aborted) npolls = 1;
    for (int i = 0; i < npolls; i++)
      expq.push_back(mkAcc(t0 + 4 + 2 * i, 1, 0, 3'd1, 32'h0));
    if (aborted) begin
      dis = t0 + stopOff + 1;
    end else if (locked) begin
      d = t0 + 4 + 2 * lockp + 2;
      for (int j = 0; j < 4; j++)
        expq.push_back(mkAcc(d + ne + j, 1, 0, 3'(3 + j), 32'h0));
      dis = d + ne + 6;
    end else begin
      dis = t0 + 4 + 2 * LT;
    end
    expq.push_back(mkAcc(dis, 0, 1, 3'd0, 32'h0));
    doneExp = dis + 1;
    passExp = locked && !aborted && (errs == 64'h0);
    if (locked && !aborted) begin
      snapBits = bits;
      snapErrs = errs;
    end

    seen    = 1'b0;
    doneCyc = -1;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge csr_clk_clk);
      start = repulse && (int'(cyc) == t0 + 3);
      if (k == 0) checkOutput("busy_after_start", busy, 1'b1);
      if (aborted && int'(cyc) == t0 + stopOff) stop = 1'b1;
      if (done) begin
        seen    = 1'b1;
        doneCyc = int'(cyc);
      end
    end
    stop  = 1'b0;
    start = 1'b0;
    if (!seen) begin
      checkOutput("done_timeout", 0, 1);
      return;
    end
    checkOutput("done_cycle", doneCyc, doneExp);
    checkOutput("pass", pass, passExp);
    checkOutput("lock_fail", lock_fail, !locked && !aborted);
    checkOutput("bit_count", bit_count, snapBits);
    checkOutput("err_count", err_count, snapErrs);
    checkOutput("busy_in_done", busy, 1'b1);
    @(negedge csr_clk_clk);
    checkOutput("done_width", done, 1'b0);
    checkOutput("busy_after_done", busy, 1'b0);
    checkOutput("pass_held", pass, passExp);

    checkOutput("acc_count", accLog.size() - logBase, expq.size());
    n = (accLog.size() - logBase < expq.size()) ? accLog.size() - logBase : expq.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("acc%0d", i), accLog[logBase + i], expq[i]);
  endtask

  // Reset asserted mid-SNAP: outputs drop asynchronously, no disable write
  task automatic resetMidSnap();
    int t0, guard, nlog;
    pattern_sel  = 3'd3;
    dwell_cycles = 32'd5;
    lockPolls    = 0;
    chkBits      = 64'h1234_5678_9ABC_DEF0;
    chkErrs      = 64'h7;
    pollBase     = statusReads;
    @(negedge csr_clk_clk);
    t0    = int'(cyc);
    start = 1'b1;
    @(negedge csr_clk_clk);
    start = 1'b0;
    guard = 0;
    while (int'(cyc) != t0 + 12 && guard < 200) begin
      @(negedge csr_clk_clk);
      guard++;
    end
    if (guard >= 200) checkOutput("snap_timeout", 0, 1);
    checkOutput("mid_snap_read", {m_read, m_address}, {1'b1, 3'd4});
    reset_reset_n = 1'b0;
    #1;
    checkOutput("rst_strobes", {m_read, m_write, m_byteenable, m_address, m_writedata}, 0);
    checkOutput("rst_flags", {busy, done, pass, lock_fail}, 4'h0);
    checkOutput("rst_counts", {bit_count, err_count}, 128'h0);
    nlog = accLog.size();
    repeat (3) @(negedge csr_clk_clk);
    checkOutput("no_access_in_reset", accLog.size(), nlog);
    reset_reset_n = 1'b1;
    snapBits = 64'h0;
    snapErrs = 64'h0;
  endtask

  initial begin
    logic [2:0]  pat;
    logic [63:0] b, e;
    int          dw, lp, so;

    #2 reset_reset_n = 1'b0;
    #1;
    checkOutput("reset_strobes", {m_read, m_write, m_byteenable, m_address, m_writedata}, 0);
    checkOutput("reset_flags", {busy, done, pass, lock_fail}, 4'h0);
    checkOutput("reset_counts", {bit_count, err_count}, 128'h0);
    repeat (2) @(negedge csr_clk_clk);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge csr_clk_clk);

    $display("[TB] directed: clean run, dwell 100");
    applyStimulus(3'd5, 100, 0, 64'h1_0000_0064, 64'h0, -1, 1'b0);
    $display("[TB] directed: errors in both halves");
    applyStimulus(3'd2, 10, 0, 64'h0000_0040_0000_1000, 64'h0000_0002_0000_0005, -1, 1'b0);
    $display("[TB] directed: lock never asserted");
    applyStimulus(3'd1, 7, 1000, 64'hDEAD, 64'h0, -1, 1'b0);
    $display("[TB] directed: stop mid-dwell");
    applyStimulus(3'd6, 20, 0, 64'h55, 64'h0, 16, 1'b0);
    $display("[TB] directed: dwell 0 with start re-pulsed");
    applyStimulus(3'd7, 0, 0, 64'h99, 64'h0, -1, 1'b1);
    $display("[TB] directed: late lock");
    applyStimulus(3'd4, 3, 5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, -1, 1'b0);
    $display("[TB] directed: reset mid-snap then normal run");
    resetMidSnap();
    applyStimulus(3'd0, 4, 0, 64'h0000_0001_0000_0002, 64'h0, -1, 1'b0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 10; r++) begin
      pat = 3'($urandom_range(0, 7));
      dw  = $urandom_range(0, 30);
      lp  = $urandom_range(0, 9);
      b   = {$urandom, $urandom};
      e   = ($urandom_range(0, 1) == 0) ? 64'h0 : {$urandom, $urandom};
      so  = -1;
      if (lp == 0 && dw >= 4 && $urandom_range(0, 2) == 0) so = 6 + dw / 2;
      applyStimulus(pat, dw, lp, b, e, so, r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
